// File: rtl/serial_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_sub_pkg : shared types and constants for the bit-serial subtractor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_sub_pkg;

  localparam int c_WIDTH_DEFAULT = 8;
  localparam int c_CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bit positions in a packed {V,N,Z} status view
  localparam int c_FLAG_Z = 0;
  localparam int c_FLAG_N = 1;
  localparam int c_FLAG_V = 2;

endpackage

`default_nettype wire

// File: rtl/serial_result_collector.sv
// ----------------------------------------------------------------------------
// serial_result_collector : LSB-first result assembly, zero accumulator and
//                           final-borrow latch for the serial subtractor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_result_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_last,
  input  logic             i_bit,
  input  logic             i_borrow,
  output logic [WIDTH-1:0] o_result_nxt,
  output logic             o_zero_nxt,
  output logic             o_borrow_nxt
);

  logic [WIDTH-1:0] r_shreg;
  logic             r_zaccum;
  logic             r_borrow;

  // Next-state views let the owner capture the completed result on the
  // same edge that consumes the final serial bit.
  assign o_result_nxt = {i_bit, r_shreg[WIDTH-1:1]};
  assign o_zero_nxt   = r_zaccum & ~i_bit;
  assign o_borrow_nxt = i_last ? i_borrow : r_borrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg  <= '0;
      r_zaccum <= 1'b0;
      r_borrow <= 1'b0;
    end else if (i_clear) begin
      r_shreg  <= '0;
      r_zaccum <= 1'b1;
      r_borrow <= 1'b0;
    end else if (i_shift) begin
      r_shreg  <= o_result_nxt;
      r_zaccum <= o_zero_nxt;
      if (i_last) begin
        r_borrow <= i_borrow;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_sub_sequencer.sv
// ----------------------------------------------------------------------------
// serial_sub_sequencer : control FSM for the bit-serial subtract datapath;
//                        result, Z/N/V flags and Done are valid together
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_sub_sequencer
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT,
  parameter int CNT_W = c_CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             St,
  input  logic [WIDTH-1:0] Minuend,
  input  logic [WIDTH-1:0] Subtrahend,
  input  logic             DiffBit,
  input  logic             BorrowOut,
  output logic             LoadEn,
  output logic             BorrowClr,
  output logic             ShiftEn,
  output logic [WIDTH-1:0] OpX,
  output logic [WIDTH-1:0] OpY,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Difference,
  output logic             StatusRegZ,
  output logic             StatusRegN,
  output logic             StatusRegV
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic             w_clear;
  logic             w_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_zero_nxt;
  logic             w_borrow_nxt;

  assign w_clear = (r_state == S_LOAD);
  assign w_shift = (r_state == S_SHIFT);
  assign w_last  = w_shift && (r_cnt == CNT_W'(WIDTH - 1));

  serial_result_collector #(
    .WIDTH (WIDTH)
  ) u_collector (
    .clk          (CLK),
    .rst          (R),
    .i_clear      (w_clear),
    .i_shift      (w_shift),
    .i_last       (w_last),
    .i_bit        (DiffBit),
    .i_borrow     (BorrowOut),
    .o_result_nxt (w_res_nxt),
    .o_zero_nxt   (w_zero_nxt),
    .o_borrow_nxt (w_borrow_nxt)
  );

  always_ff @(posedge CLK) begin
    if (R) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      LoadEn     <= 1'b0;
      BorrowClr  <= 1'b0;
      ShiftEn    <= 1'b0;
      OpX        <= '0;
      OpY        <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Difference <= '0;
      StatusRegZ <= 1'b0;
      StatusRegN <= 1'b0;
      StatusRegV <= 1'b0;
    end else begin
      LoadEn    <= 1'b0;
      BorrowClr <= 1'b0;
      ShiftEn   <= 1'b0;
      Done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (St) begin
            OpX       <= Minuend;
            OpY       <= Subtrahend;
            LoadEn    <= 1'b1;
            BorrowClr <= 1'b1;
            Busy      <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          ShiftEn <= 1'b1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_last) begin
            // Outputs are registered, so DONE's results load on entry
            r_cnt      <= '0;
            Done       <= 1'b1;
            Difference <= w_res_nxt;
            StatusRegZ <= w_zero_nxt;
            StatusRegN <= w_borrow_nxt;
            StatusRegV <= (OpX[WIDTH-1] ^ OpY[WIDTH-1]) &
                          (OpX[WIDTH-1] ^ w_res_nxt[WIDTH-1]);
            r_state    <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            ShiftEn <= 1'b1;
          end
        end
        S_DONE: begin
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_sequencer.sv
// ----------------------------------------------------------------------------
// tb_serial_sub_sequencer : directed bench with a behavioural serial subtractor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub_sequencer;

  logic       CLK = 1'b0;
  logic       R = 1'b1;
  logic       St = 1'b0;
  logic [7:0] Minuend = 8'h00;
  logic [7:0] Subtrahend = 8'h00;
  logic       DiffBit;
  logic       BorrowOut;
  logic       LoadEn, BorrowClr, ShiftEn, Busy, Done;
  logic [7:0] OpX, OpY, Difference;
  logic       StatusRegZ, StatusRegN, StatusRegV;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;

  serial_sub_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .R(R), .St(St), .Minuend(Minuend), .Subtrahend(Subtrahend),
    .DiffBit(DiffBit), .BorrowOut(BorrowOut), .LoadEn(LoadEn),
    .BorrowClr(BorrowClr), .ShiftEn(ShiftEn), .OpX(OpX), .OpY(OpY),
    .Busy(Busy), .Done(Done), .Difference(Difference),
    .StatusRegZ(StatusRegZ), .StatusRegN(StatusRegN), .StatusRegV(StatusRegV)
  );

  always #5 CLK = ~CLK;

  // Behavioural serial datapath: accumulator, subtrahend register, borrow FF
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic       m_br = 1'b0;

  assign DiffBit   = m_a[0] ^ m_b[0] ^ m_br;
  assign BorrowOut = (~m_a[0] & m_b[0]) | (~(m_a[0] ^ m_b[0]) & m_br);

  always @(posedge CLK) begin
    if (LoadEn) begin
      m_a <= OpX;
      m_b <= OpY;
    end else if (ShiftEn) begin
      m_a <= {DiffBit, m_a[7:1]};
      m_b <= {1'b0, m_b[7:1]};
    end
    if (BorrowClr) m_br <= 1'b0;
    else if (ShiftEn) m_br <= BorrowOut;
  end

  always @(negedge CLK) begin
    if (!R && (((int'(LoadEn) + int'(ShiftEn) + int'(Done)) > 1) || (BorrowClr && !LoadEn)))
      viol++;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Starts one operation and counts edges from acceptance to Done (-1 on timeout)
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int busy_n);
    Minuend = x; Subtrahend = y; St = 1'b1;
    tick;
    St = 1'b0;
    lat = 1;
    busy_n = Busy ? 1 : 0;
    while (!Done && lat < 40) begin
      tick;
      lat++;
      if (Busy) busy_n++;
    end
    if (!Done) lat = -1;
  endtask

  task automatic test_reset;
    R = 1'b1;
    tick; tick;
    n_cmp++;
    if ({LoadEn, BorrowClr, ShiftEn, Busy, Done, StatusRegZ, StatusRegN, StatusRegV} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 00000000",
               {LoadEn, BorrowClr, ShiftEn, Busy, Done, StatusRegZ, StatusRegN, StatusRegV});
    end
    n_cmp++;
    if ({OpX, OpY, Difference} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 000000", {OpX, OpY, Difference});
    end
    R = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    int lat, busy_n;
    run_op(8'h34, 8'hF7, lat, busy_n);
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL basic_latency: got %0d want 10", lat); end
    n_cmp++;
    if (busy_n !== 10) begin n_err++; $display("FAIL basic_busy: got %0d want 10", busy_n); end
    n_cmp++;
    if (Difference !== 8'h3D) begin n_err++; $display("FAIL basic_diff: got %h want 3d", Difference); end
    n_cmp++;
    if ({StatusRegZ, StatusRegN, StatusRegV} !== 3'b010) begin
      n_err++; $display("FAIL basic_flags: got %b want 010", {StatusRegZ, StatusRegN, StatusRegV});
    end
    tick;
    n_cmp++;
    if ({Done, Busy} !== 2'b00) begin n_err++; $display("FAIL basic_end: got %b want 00", {Done, Busy}); end
    tick; tick; tick;
    n_cmp++;
    if (Difference !== 8'h3D) begin n_err++; $display("FAIL basic_hold: got %h want 3d", Difference); end
  endtask

  task automatic test_zero;
    int lat, busy_n;
    run_op(8'h55, 8'h55, lat, busy_n);
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL zero_latency: got %0d want 10", lat); end
    n_cmp++;
    if (Difference !== 8'h00) begin n_err++; $display("FAIL zero_diff: got %h want 00", Difference); end
    n_cmp++;
    if ({StatusRegZ, StatusRegN, StatusRegV} !== 3'b100) begin
      n_err++; $display("FAIL zero_flags: got %b want 100", {StatusRegZ, StatusRegN, StatusRegV});
    end
    tick;
  endtask

  task automatic test_overflow;
    int lat, busy_n;
    run_op(8'h80, 8'h01, lat, busy_n);
    n_cmp++;
    if (Difference !== 8'h7F) begin n_err++; $display("FAIL ovf_diff: got %h want 7f", Difference); end
    n_cmp++;
    if ({StatusRegZ, StatusRegN, StatusRegV} !== 3'b001) begin
      n_err++; $display("FAIL ovf_flags: got %b want 001", {StatusRegZ, StatusRegN, StatusRegV});
    end
    tick;
  endtask

  task automatic test_negative;
    int lat, busy_n;
    run_op(8'h00, 8'h01, lat, busy_n);
    n_cmp++;
    if (Difference !== 8'hFF) begin n_err++; $display("FAIL neg_diff: got %h want ff", Difference); end
    n_cmp++;
    if ({StatusRegZ, StatusRegN, StatusRegV} !== 3'b010) begin
      n_err++; $display("FAIL neg_flags: got %b want 010", {StatusRegZ, StatusRegN, StatusRegV});
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int d_cnt = 0;
    int d_first = -1;
    int d_second = -1;
    int guard = 0;
    Minuend = 8'h00; Subtrahend = 8'h01; St = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (Done) begin
        d_cnt++;
        if (d_first < 0) d_first = i;
        else if (d_second < 0) d_second = i;
      end
    end
    St = 1'b0;
    n_cmp++;
    if (d_cnt !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", d_cnt); end
    n_cmp++;
    if (d_first !== 10) begin n_err++; $display("FAIL b2b_first: got %0d want 10", d_first); end
    n_cmp++;
    if ((d_second - d_first) !== 11) begin
      n_err++; $display("FAIL b2b_period: got %0d want 11", d_second - d_first);
    end
    while (Busy && guard < 40) begin tick; guard++; end
    n_cmp++;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain: busy %b want 0", Busy); end
    n_cmp++;
    if (Difference !== 8'hFF) begin n_err++; $display("FAIL b2b_diff: got %h want ff", Difference); end
    tick;
  endtask

  task automatic test_reset_abort;
    int lat, busy_n;
    int seen = 0;
    Minuend = 8'h34; Subtrahend = 8'hF7; St = 1'b1;
    tick;
    St = 1'b0;
    tick; tick; tick; tick;
    R = 1'b1;
    tick;
    n_cmp++;
    if ({LoadEn, BorrowClr, ShiftEn, Busy, Done, StatusRegZ, StatusRegN, StatusRegV} !== 8'h00) begin
      n_err++;
      $display("FAIL abort_ctl: got %b want 00000000",
               {LoadEn, BorrowClr, ShiftEn, Busy, Done, StatusRegZ, StatusRegN, StatusRegV});
    end
    n_cmp++;
    if ({OpX, OpY, Difference} !== 24'h0) begin
      n_err++; $display("FAIL abort_data: got %h want 000000", {OpX, OpY, Difference});
    end
    R = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (Done || Busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL abort_nodone: got %0d active cycles want 0", seen); end
    run_op(8'h10, 8'h01, lat, busy_n);
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL abort_relat: got %0d want 10", lat); end
    n_cmp++;
    if (Difference !== 8'h0F) begin n_err++; $display("FAIL abort_rediff: got %h want 0f", Difference); end
    n_cmp++;
    if ({StatusRegZ, StatusRegN, StatusRegV} !== 3'b000) begin
      n_err++; $display("FAIL abort_reflags: got %b want 000", {StatusRegZ, StatusRegN, StatusRegV});
    end
    tick;
  endtask

  task automatic test_ignore_st;
    int lat;
    Minuend = 8'hA3; Subtrahend = 8'h5C; St = 1'b1;
    tick;
    St = 1'b0;
    lat = 1;
    tick; tick;
    lat = 3;
    St = 1'b1; Minuend = 8'hFF; Subtrahend = 8'h00;
    while (!Done && lat < 40) begin tick; lat++; end
    St = 1'b0;
    n_cmp++;
    if (lat !== 10) begin n_err++; $display("FAIL ign_latency: got %0d want 10", lat); end
    n_cmp++;
    if (Difference !== 8'h47) begin n_err++; $display("FAIL ign_diff: got %h want 47", Difference); end
    n_cmp++;
    if ({StatusRegZ, StatusRegN, StatusRegV} !== 3'b001) begin
      n_err++; $display("FAIL ign_flags: got %b want 001", {StatusRegZ, StatusRegN, StatusRegV});
    end
    tick; tick;
    n_cmp++;
    if (Busy !== 1'b0) begin n_err++; $display("FAIL ign_noqueue: busy %b want 0", Busy); end
  endtask

  task automatic test_strobes;
    n_cmp++;
    if (viol !== 0) begin n_err++; $display("FAIL strobe_excl: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero;
    test_overflow;
    test_negative;
    test_back_to_back;
    test_reset_abort;
    test_ignore_st;
    test_strobes;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_sub_sequencer.md
Name: serial_sub_sequencer

Overview:
- Control FSM for the bit-serial subtract datapath: the LSB-first accumulator and subtrahend shift registers, the borrow flip-flop and the full subtractor.
- Accepts a start request and loads both operands into the datapath.
- Clears the borrow, then runs exactly WIDTH shift cycles.
- Assembles the serial difference into a parallel result, derives Z/N/V flags from the serial stream and reports completion with a one-cycle Done pulse.
- Replaces free-running testbench timing as the owner of all datapath control strobes.

Parameters:
- WIDTH, 8, operand/result width in bits; also the shift count per operation.
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- R  input  1  reset, synchronous, active-high
- St  input  1  start request, sampled only in IDLE
- Minuend  input  WIDTH  operand X, captured on St acceptance
- Subtrahend  input  WIDTH  operand Y, captured on St acceptance
- DiffBit  input  1  serial difference bit from the full subtractor, valid in SHIFT cycles
- BorrowOut  input  1  borrow-out from the full subtractor, valid in SHIFT cycles
- LoadEn  output  1  parallel-load strobe to both shift registers
- BorrowClr  output  1  reset to the borrow flip-flop
- ShiftEn  output  1  shift-enable to both shift registers
- OpX  output  WIDTH  captured minuend driven to the accumulator load port
- OpY  output  WIDTH  captured subtrahend driven to the subtrahend load port
- Busy  output  1  high from St acceptance until Done inclusive
- Done  output  1  one-cycle completion pulse
- Difference  output  WIDTH  result, held stable from Done until the next Done
- StatusRegZ  output  1  result == 0
- StatusRegN  output  1  final borrow, meaning unsigned X < Y
- StatusRegV  output  1  two's-complement overflow of X - Y

Behaviour:
- Reset (R=1 at a rising edge):
  - State goes to IDLE and the counter clears.
  - All outputs are 0, including OpX/OpY, Difference and the flags.
  - Reset overrides every other input in the same cycle.
  - Reset mid-operation aborts the operation: no Done, Difference and flags cleared.
- States:
  - IDLE: Busy=0. If St=1, capture Minuend/Subtrahend into OpX/OpY and go to LOAD.
  - LOAD (1 cycle): LoadEn=1, BorrowClr=1, counter cleared, Z accumulator set to 1. Go to SHIFT.
  - SHIFT (exactly WIDTH cycles, counter 0..WIDTH-1): ShiftEn=1. Each cycle:
    - shift DiffBit into the result register MSB (LSB-first assembly);
    - zaccum <= zaccum & ~DiffBit.
    - On counter == WIDTH-1, latch BorrowOut as the final borrow and go to DONE.
  - DONE (1 cycle): Done=1.
    - Difference <= assembled register; StatusRegZ <= zaccum; StatusRegN <= final borrow.
    - StatusRegV <= (OpX[MSB] ^ OpY[MSB]) & (OpX[MSB] ^ assembled[MSB]).
    - Always go to IDLE.
- Timing:
  - St accepted at edge k gives LOAD in cycle k+1, SHIFT in k+2..k+WIDTH+1 and Done in cycle k+WIDTH+2.
  - Minimum St-to-St period is WIDTH+3 cycles. St held high continuously restarts a new operation every WIDTH+3 cycles.
- St in any state other than IDLE is ignored; it is neither queued nor does it disturb the operation.
- Minuend/Subtrahend changing after acceptance has no effect; only OpX/OpY are used.
- Strobes are mutually exclusive: LoadEn, ShiftEn and Done are never high together. BorrowClr is high only in LOAD.
- Width rules:
  - All arithmetic is modulo 2**WIDTH.
  - The counter never exceeds WIDTH-1; an illegal state encoding returns to IDLE.
- Difference and flags are updated only in DONE; they hold their previous values in every other state.

Decomposition:
- Shared package serial_sub_pkg:
  - state enum (IDLE, LOAD, SHIFT, DONE) and its encoding;
  - the WIDTH default;
  - flag bit index constants Z=0, N=1, V=2 for any packed status view.
- One sub-module, serial_result_collector: result shift register, zaccum and final-borrow latch, controlled by clear/shift/last inputs.
- The FSM and counter stay in serial_sub_sequencer.

Test Plan:
- Bench connects a behavioural posedge serial subtractor model (shift registers, borrow FF, full subtractor) to the strobes.
- X=0x34, Y=0xF7, St pulse -> Done exactly 10 cycles after acceptance; Difference=0x3D, Z=0, N=1, V=0; Busy high 10 cycles.
- X=0x55, Y=0x55 -> Difference=0x00, Z=1, N=0, V=0.
- X=0x80, Y=0x01 -> Difference=0x7F, Z=0, N=0, V=1.
- X=0x00, Y=0x01 -> Difference=0xFF, Z=0, N=1, V=0. Then St held high for 30 cycles -> Done pulses exactly 11 cycles apart.
- Accept X=0x34, Y=0xF7, assert R in the 4th SHIFT cycle -> next cycle all outputs 0, state IDLE, no Done. A following St with X=0x10, Y=0x01 -> Difference=0x0F, Z=0, N=0, V=0.
- St re-pulsed and Minuend/Subtrahend changed during SHIFT -> no restart; result matches the originally captured operands.
